// File: rtl/zero_predictor_reader.sv
// Serial reader for the sixth-order ADPCM zero predictor: fetches (B, DQ) tap pairs,
// forms the G.721 FMULT product of each pair and accumulates the products into SEZI/SEZ.
module zero_predictor_reader #(
  parameter int NTAPS  = 6,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_b,
  input  logic [10:0]       rd_dq,
  output logic              busy,
  output logic              done,
  output logic [15:0]       sezi,
  output logic [14:0]       sez
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NTAPS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_dvalid;
  logic [15:0]       r_acc;
  logic [15:0]       r_sezi;

  logic        w_an_s;
  logic [15:0] w_b_neg;
  logic [12:0] w_an_mag;
  logic [3:0]  w_an_exp;
  logic [18:0] w_mag_sh;
  logic [5:0]  w_an_mant;
  logic        w_ws;
  logic [4:0]  w_wexp;
  logic [12:0] w_wmant_full;
  logic [7:0]  w_wmant;
  logic [16:0] w_big;
  logic [16:0] w_shr;
  logic [16:0] w_shl;
  logic [14:0] w_wmag;
  logic [15:0] w_wmag16;
  logic [15:0] w_wb;
  logic        w_unused;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_READ;
      S_READ:  if (r_addr == LAST_ADDR) w_next = S_DRAIN;
      S_DRAIN: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en   = (r_state == S_READ);
    busy    = (r_state != S_IDLE);
    done    = (r_state == S_DONE);
    rd_addr = r_addr;
    sezi    = r_sezi;
    sez     = r_sezi[15:1];
  end

  // Read data lags rd_en by one cycle, so r_dvalid marks the cycles that carry a tap pair.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr   <= '0;
      r_dvalid <= 1'b0;
      r_acc    <= '0;
      r_sezi   <= '0;
    end else begin
      r_dvalid <= (r_state == S_READ);
      if (r_state == S_READ && r_addr != LAST_ADDR) r_addr <= r_addr + ADDR_W'(1);
      else                                          r_addr <= '0;
      if (r_state == S_IDLE && start) r_acc <= '0;
      else if (r_dvalid)              r_acc <= r_acc + w_wb;
      // The last product arrives in DRAIN; fold it in directly so sezi is valid with done.
      if (r_state == S_DRAIN) r_sezi <= r_acc + w_wb;
    end
  end

  // FMULT: convert B to a 4-bit-exponent float, multiply by DQ, convert back to linear.
  always_comb begin
    w_an_s   = rd_b[15];
    w_b_neg  = 16'd0 - rd_b;
    w_an_mag = w_an_s ? w_b_neg[14:2] : rd_b[14:2];
    w_an_exp = 4'd0;
    for (int k = 0; k < 13; k++) begin
      if (w_an_mag[k]) w_an_exp = 4'(k + 1);
    end
    w_mag_sh     = {w_an_mag, 6'b0} >> w_an_exp;
    w_an_mant    = (w_an_mag == 13'd0) ? 6'd32 : w_mag_sh[5:0];
    w_ws         = rd_dq[10] ^ w_an_s;
    w_wexp       = {1'b0, rd_dq[9:6]} + {1'b0, w_an_exp};
    w_wmant_full = {1'b0, 12'(rd_dq[5:0] * w_an_mant)} + 13'd48;
    w_wmant      = w_wmant_full[11:4];
    w_big        = {2'b0, w_wmant, 7'b0};
    w_shr        = w_big >> (5'd26 - w_wexp);
    w_shl        = w_big << (w_wexp - 5'd26);
    w_wmag       = (w_wexp <= 5'd26) ? w_shr[14:0] : w_shl[14:0];
    w_wmag16     = {1'b0, w_wmag};
    w_wb         = w_ws ? (16'd0 - w_wmag16) : w_wmag16;
  end

  assign w_unused = ^{rd_b[1:0], w_b_neg[15], w_b_neg[1:0], w_mag_sh[18:6],
                      w_wmant_full[12], w_wmant_full[3:0], w_shr[16:15], w_shl[16:15]};

endmodule

// File: tb/tb_zero_predictor_reader.sv
// Directed bench for zero_predictor_reader: tap memory responder, cycle-exact control
// checks and hand-computed FMULT sums.
module tb_zero_predictor_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [15:0] rd_b = '0;
  logic [10:0] rd_dq = '0;
  logic        busy;
  logic        done;
  logic [15:0] sezi;
  logic [14:0] sez;

  int checks = 0;
  int errors = 0;

  logic [15:0] tap_b  [6];
  logic [10:0] tap_dq [6];

  zero_predictor_reader #(.NTAPS(6), .ADDR_W(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_b    (rd_b),
    .rd_dq   (rd_dq),
    .busy    (busy),
    .done    (done),
    .sezi    (sezi),
    .sez     (sez)
  );

  always #5 clk = ~clk;

  // Tap bank: data for the strobed address appears the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_b  <= tap_b[rd_addr];
      rd_dq <= tap_dq[rd_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
      else begin
        errors++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
  endtask

  task automatic set_taps(input logic [15:0] b0, input logic [10:0] dq0,
                          input logic [15:0] b_rest, input logic [10:0] dq_rest);
    tap_b[0]  = b0;
    tap_dq[0] = dq0;
    for (int i = 1; i < 6; i++) begin
      tap_b[i]  = b_rest;
      tap_dq[i] = dq_rest;
    end
  endtask

  // Start at edge 0, then inspect cycles 1..11 at the falling edge.
  task automatic run_estimate(input string tag, input bit extra_starts,
                              input logic [15:0] exp_sezi, input logic [14:0] exp_sez);
    int reads;
    int dones;
    reads = 0;
    dones = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start = extra_starts && (c == 3 || c == 8);
      check($sformatf("%s_ctrl_c%0d", tag, c), {rd_en, busy, done},
            {(c <= 6), (c <= 8), (c == 8)});
      if (rd_en) begin
        check($sformatf("%s_addr_c%0d", tag, c), rd_addr, c - 1);
        reads++;
      end
      if (done) dones++;
      if (c == 8) begin
        check($sformatf("%s_sezi", tag), sezi, exp_sezi);
        check($sformatf("%s_sez", tag), sez, exp_sez);
      end
    end
    start = 1'b0;
    check($sformatf("%s_reads", tag), reads, 6);
    check($sformatf("%s_dones", tag), dones, 1);
    check($sformatf("%s_sezi_hold", tag), sezi, exp_sezi);
  endtask

  initial begin
    set_taps(16'h0000, 11'h000, 16'h0000, 11'h000);
    repeat (2) @(negedge clk);
    check("rst_ctrl", {rd_en, busy, done}, 3'b000);
    check("rst_addr", rd_addr, 0);
    check("rst_sezi", sezi, 16'h0000);
    check("rst_sez", sez, 15'h0000);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ctrl", {rd_en, busy, done}, 3'b000);

    // B = 0 on every tap with small DQ exponents: every product rounds to zero.
    tap_b  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tap_dq = '{11'h1E0, 11'h2A5, 11'h4C3, 11'h020, 11'h000, 11'h28F};
    run_estimate("zero", 1'b0, 16'h0000, 15'h0000);

    set_taps(16'h4000, 11'h1E0, 16'h0000, 11'h000);
    run_estimate("pos64", 1'b0, 16'h0086, 15'h0043);

    set_taps(16'hC000, 11'h1E0, 16'h0000, 11'h000);
    run_estimate("neg64", 1'b0, 16'hFF7A, 15'h7FBD);

    set_taps(16'h4000, 11'd32, 16'h4000, 11'd32);
    run_estimate("dq_rst", 1'b0, 16'h0006, 15'h0003);

    set_taps(16'h4000, {1'b0, 4'd15, 6'd32}, 16'h0000, 11'h000);
    run_estimate("masked", 1'b0, 16'h0600, 15'h0300);

    // Restarts during READ and in the DONE cycle must be dropped.
    set_taps(16'h4000, 11'h1E0, 16'h0000, 11'h000);
    run_estimate("restart", 1'b1, 16'h0086, 15'h0043);

    // Asynchronous reset in the middle of the read sequence.
    set_taps(16'h4000, 11'd32, 16'h4000, 11'd32);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_pre", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("abort_ctrl", {rd_en, busy, done}, 3'b000);
    check("abort_addr", rd_addr, 0);
    check("abort_sezi", sezi, 16'h0000);
    check("abort_sez", sez, 15'h0000);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_abort_ctrl", {rd_en, busy, done}, 3'b000);
    run_estimate("after_rst", 1'b0, 16'h0006, 15'h0003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
